// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: assembles WIDTH-bit words from a serial stream
// (MSB- or LSB-first per word) and buffers them in a DEPTH-word output FIFO.
module sipo_deframer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sin,
   input  logic                       sin_valid,
   input  logic                       shift_mode,
   input  logic                       frame_sync,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [$clog2(WIDTH)-1:0]   bit_cnt,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] r_sreg;
   logic [CNT_W-1:0] r_bit_cnt;
   logic             r_mode;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_valid;
   logic             r_overflow;

   logic             w_first;
   logic             w_mode;
   logic [WIDTH-1:0] w_base;
   logic [CNT_W-1:0] w_cnt_base;
   logic [WIDTH-1:0] w_word;
   logic             w_last;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_wr_en;
   logic [PTR_W-1:0] w_rd_next;
   logic [LVL_W-1:0] w_level_next;

   // frame_sync makes the current bit the first of a fresh word
   assign w_first    = frame_sync || (r_bit_cnt == '0);
   assign w_mode     = w_first ? shift_mode : r_mode;
   assign w_base     = frame_sync ? '0 : r_sreg;
   assign w_cnt_base = frame_sync ? '0 : r_bit_cnt;
   assign w_word     = w_mode ? {sin, w_base[WIDTH-1:1]} : {w_base[WIDTH-2:0], sin};
   assign w_last     = !frame_sync && (r_bit_cnt == CNT_W'(WIDTH - 1));
   assign w_push     = sin_valid && w_last;
   assign w_pop      = r_dout_valid && dout_ready;
   assign w_full     = (r_level == LVL_W'(DEPTH));
   assign w_wr_en    = w_push && (!w_full || w_pop);
   assign w_rd_next  = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

   always_comb begin
      w_level_next = r_level;
      if (w_wr_en && !w_pop)
         w_level_next = r_level + LVL_W'(1);
      else if (!w_wr_en && w_pop)
         w_level_next = r_level - LVL_W'(1);
   end

   // Shifter, bit counter and per-word mode latch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sreg    <= '0;
         r_bit_cnt <= '0;
         r_mode    <= 1'b0;
      end else if (sin_valid) begin
         if (w_first)
            r_mode <= shift_mode;
         if (w_last) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
         end else begin
            r_sreg    <= w_word;
            r_bit_cnt <= w_cnt_base + CNT_W'(1);
         end
      end else if (frame_sync) begin
         r_sreg    <= '0;
         r_bit_cnt <= '0;
      end
   end

   // FIFO storage, pointers and registered head word
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++)
            r_mem[i] <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_word;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         r_rd_ptr     <= w_rd_next;
         r_level      <= w_level_next;
         r_dout_valid <= (w_level_next != '0);
         // Bypass when the new head is the slot being written this edge
         r_dout       <= (w_wr_en && (r_wr_ptr == w_rd_next)) ? w_word : r_mem[w_rd_next];
         if (w_push && w_full && !w_pop)
            r_overflow <= 1'b1;
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign bit_cnt    = r_bit_cnt;
   assign fifo_level = r_level;
   assign overflow   = r_overflow;

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
Downstream consumer of the 4-bit parallel-in/serial-out shifter. It collects the serial bit stream back into WIDTH-bit words and honours the same shift_mode bit-order convention. Completed words are buffered in a small FIFO and presented on a valid/ready handshake. It provides realignment through frame_sync and a sticky overflow flag for words lost when the FIFO is full.

Parameters:
WIDTH, 4, word width in bits (>=2)
DEPTH, 2, output FIFO depth in words (power of 2, >=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled on this edge when high
shift_mode  input  1  bit order: 0 = MSB-first, 1 = LSB-first; latched per word
frame_sync  input  1  discard the partial word and realign to bit 0
dout  output  WIDTH  FIFO head word
dout_valid  output  1  FIFO not empty
dout_ready  input  1  consumer accepts dout when dout_valid is high
bit_cnt  output  $clog2(WIDTH)  bits collected in the current word
fifo_level  output  $clog2(DEPTH)+1  words held in the FIFO
overflow  output  1  sticky; a completed word was dropped

Behaviour:
- Reset (rst=1 at a clk edge): shift register, bit_cnt, FIFO pointers and fifo_level are 0; dout=0; dout_valid=0; overflow=0; latched mode=0. Reset overrides all other inputs in that cycle. A partial word in progress is discarded.
- Mode latch:
  - When sin_valid=1 and bit_cnt=0, shift_mode is captured for the whole word.
  - Changes to shift_mode mid-word have no effect until the next word.
  - The captured mode applies to the bit sampled on that same edge.
- Bit capture (sin_valid=1):
  - Mode 0: the word is assembled MSB-first. The first bit lands in dout[WIDTH-1] and the completed word equals {sreg[WIDTH-2:0], sin}.
  - Mode 1: the word is assembled LSB-first. The first bit lands in dout[0] and the completed word equals {sin, sreg[WIDTH-1:1]}.
  - bit_cnt increments and wraps to 0 after WIDTH-1.
- Word completion (sin_valid=1 and bit_cnt=WIDTH-1):
  - The assembled word, including the current sin, is pushed on that same edge.
  - dout_valid is high in the following cycle when the FIFO was empty, giving 1-cycle latency from the last bit to output.
  - The shift register clears.
- sin_valid=0: no state change in the shifter; bit_cnt holds.
- frame_sync=1:
  - bit_cnt and the shift register clear and no push occurs, even if bit_cnt=WIDTH-1.
  - If sin_valid=1 in the same cycle, that bit becomes bit 0 of the new word and shift_mode is latched for it.
  - The FIFO is unaffected.
- FIFO:
  - Pop when dout_valid && dout_ready.
  - dout is registered from the FIFO head and holds stable while dout_valid=1 and dout_ready=0.
- Simultaneous push and pop: both are performed and fifo_level is unchanged. This holds when the FIFO is full, so no drop occurs.
- Push when full without a pop: the word is discarded, overflow is set, and FIFO contents and level are unchanged.
- overflow clears only on rst.
- Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.

Test Plan:
- Reset: rst=1 for 2 cycles with sin_valid=1 and sin=1 → dout=0, dout_valid=0, bit_cnt=0, fifo_level=0, overflow=0 throughout.
- MSB-first: shift_mode=0 and bits 1,0,1,1 on consecutive edges with dout_ready=0 → the cycle after the 4th bit shows dout=4'b1011, dout_valid=1, fifo_level=1, bit_cnt=0.
- LSB-first, mode latch and holes:
  - Stimulus: shift_mode=1 at the first bit, bits 1,0,1,1, shift_mode toggled to 0 after bit 2, sin_valid=0 for 3 cycles between bits 2 and 3.
  - Required response: dout=4'b1101; bit_cnt holds at 2 during the gap.
- Overflow: dout_ready=0 and three full words A=4'h3, B=4'hC, C=4'h5 (mode 0) → fifo_level=2, overflow=1 after C. Raising dout_ready then gives the pop sequence 4'h3 then 4'hC, after which dout_valid=0.
- Full push+pop:
  - Stimulus: FIFO full (4'h1, 4'h2); a 4th bit of word 4'h7 completes in the same cycle as dout_ready=1.
  - Required response: no overflow; fifo_level stays 2; subsequent pops give 4'h2 then 4'h7.
- frame_sync: after 2 bits, frame_sync=1 with sin_valid=1 and sin=1, followed by bits 1,1,0 (mode 0) → no push for the aborted word; next dout=4'b1110. A mid-word rst likewise discards the partial word.
